// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I core: opcodes, datapath mux selects,
// ALU controls and the control FSM state type.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_PASSB = 3'b110;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASSB = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECUTER,
    S_EXECUTEI, S_LUI, S_ALUWB, S_JAL, S_BEQ, S_TRAP
  } state_t;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps the FSM's aluop class plus instruction fields to an ALU control.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       opb5,
  input  logic       funct7b5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD:   alucontrol = ALU_ADD;
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_PASSB: alucontrol = ALU_PASSB;
      default: begin
        // funct7b5 only selects sub for R-type; addi reuses that bit as immediate
        case (funct3)
          3'b000:  alucontrol = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I core; sequences the shared datapath
// through fetch/decode/execute/memory/writeback from the latched instruction.
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [2:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic       adrsrc,
  output logic [2:0] alucontrol,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       illegal
);

  state_t     state, state_nxt;
  logic [1:0] aluop;
  logic       pcupdate;
  logic       branch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXECUTER;
          OP_ITYPE:          state_nxt = S_EXECUTEI;
          OP_JAL:            state_nxt = S_JAL;
          OP_BRANCH:         state_nxt = S_BEQ;
          OP_LUI:            state_nxt = S_LUI;
          default:           state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR:   state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_nxt = S_MEMWB;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: state_nxt = S_FETCH;
      S_EXECUTER: state_nxt = S_ALUWB;
      S_EXECUTEI: state_nxt = S_ALUWB;
      S_LUI:      state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_JAL:      state_nxt = S_ALUWB;
      S_BEQ:      state_nxt = S_FETCH;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    alusrca   = SRCA_PC;
    alusrcb   = SRCB_RD2;
    resultsrc = RES_ALUOUT;
    adrsrc    = 1'b0;
    aluop     = ALUOP_ADD;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    memwrite  = 1'b0;
    pcupdate  = 1'b0;
    branch    = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_FETCH: begin
        irwrite   = 1'b1;
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALURESULT;
        pcupdate  = 1'b1;
      end
      S_DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
      end
      S_MEMADR: begin
        alusrca = SRCA_RD1;
        alusrcb = SRCB_IMM;
      end
      S_MEMREAD: adrsrc = 1'b1;
      S_MEMWB: begin
        resultsrc = RES_DATA;
        regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTER: begin
        alusrca = SRCA_RD1;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        alusrca = SRCA_RD1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
      end
      S_LUI: begin
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_PASSB;
      end
      S_ALUWB: regwrite = 1'b1;
      S_JAL: begin
        alusrca  = SRCA_OLDPC;
        alusrcb  = SRCB_FOUR;
        pcupdate = 1'b1;
      end
      S_BEQ: begin
        alusrca = SRCA_RD1;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

  // Branch resolution is combinational on the ALU zero flag in the BEQ cycle
  assign pcwrite = pcupdate | (branch & zero);

  always_comb begin
    case (op)
      OP_STORE:  immsrc = IMM_S;
      OP_BRANCH: immsrc = IMM_B;
      OP_JAL:    immsrc = IMM_J;
      OP_LUI:    immsrc = IMM_U;
      default:   immsrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .opb5       (op[5]),
    .funct7b5   (funct7b5),
    .alucontrol (alucontrol)
  );

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM for the multicycle RV32I core. Sequences the shared datapath (single ALU, single memory port, instruction register, immediate extender) through fetch, decode, execute, memory and writeback steps. Drives every datapath select/enable each cycle from the latched instruction fields and the ALU zero flag. Sits beside the datapath inside the core top level.

## Interface
Parameters: none.

Ports:
- `clk` in 1: core clock, rising-edge.
- `reset` in 1: asynchronous, active-high; forces FETCH.
- `op` in 7: `instr[6:0]` from instruction register.
- `funct3` in 3: `instr[14:12]`.
- `funct7b5` in 1: `instr[30]`.
- `zero` in 1: ALU result == 0.
- `immsrc` out 3: extender select; 000 I, 001 S, 010 B, 011 J, 100 U.
- `alusrca` out 2: 00 PC, 01 OldPC, 10 RD1.
- `alusrcb` out 2: 00 RD2, 01 ImmExt, 10 constant 4.
- `resultsrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `adrsrc` out 1: memory address; 0 PC, 1 Result.
- `alucontrol` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt, 110 pass-B.
- `irwrite`, `pcwrite`, `regwrite`, `memwrite` out 1 each: enables.
- `illegal` out 1: high while in TRAP.

## Operation
- `immsrc` is a function of `op` only: lw/I-ALU 000, sw 001, beq 010, jal 011, lui 100, other 000.
- All other outputs are decoded from state. Exception: `pcwrite = pcupdate | (branch & zero)`.
- Unlisted outputs are 0 or 00. `aluop` is internal.
- States, outputs, and next state:
  - FETCH: adrsrc 0, irwrite, alusrca 00, alusrcb 10, aluop 00, resultsrc 10, pcupdate. Next DECODE.
  - DECODE: alusrca 01, alusrcb 01, aluop 00. Next by `op`:
    - 0000011/0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1101111 → JAL
    - 1100011 → BEQ
    - 0110111 → LUI
    - else TRAP
  - MEMADR: alusrca 10, alusrcb 01, aluop 00. Next MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: resultsrc 00, adrsrc 1. Next MEMWB.
  - MEMWB: resultsrc 01, regwrite. Next FETCH.
  - MEMWRITE: resultsrc 00, adrsrc 1, memwrite. Next FETCH.
  - EXECUTER: alusrca 10, alusrcb 00, aluop 10. Next ALUWB.
  - EXECUTEI: alusrca 10, alusrcb 01, aluop 10. Next ALUWB.
  - LUI: alusrcb 01, aluop 11. Next ALUWB.
  - ALUWB: resultsrc 00, regwrite. Next FETCH.
  - JAL: alusrca 01, alusrcb 10, aluop 00, resultsrc 00, pcupdate. Next ALUWB.
  - BEQ: alusrca 10, alusrcb 00, aluop 01, resultsrc 00, branch. Next FETCH.
  - TRAP: all enables 0, illegal 1. Stays until reset.
- ALU decode:
  - aluop 00 → add; 01 → sub; 11 → pass-B.
  - aluop 10 by funct3: 000 add, or sub when op[5]&funct7b5; 010 slt; 110 or; 111 and; other funct3 → add.

## Timing
- State register updates on the rising edge of `clk`; `reset` clears it asynchronously to FETCH.
- Outputs during and just after reset are the FETCH values: irwrite 1, pcwrite 1, alusrcb 10, resultsrc 10, all else 0. `immsrc` follows `op`.
- Cycles per instruction: lw 5; sw, R, I-ALU, lui, jal 4; beq 3.
- `pcwrite` in BEQ reacts combinationally to `zero` in the same cycle.
- Reset asserted mid-instruction: abandon the instruction. No write enable may be high in the cycle after reset deasserts except FETCH's irwrite/pcwrite.
- No stall input: memory is single-cycle.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants
  - immsrc, alusrca/b, resultsrc and alucontrol encodings
  - state enum, 4 bits
- Extender and datapath import the same immsrc/alucontrol constants.
- One sub-module: `alu_decoder` (aluop, funct3, op[5], funct7b5 → alucontrol).
- Next-state and output logic stay in `multicycle_controller`.

## Test plan
- Reset pulse mid-MEMREAD, then release. Required: state FETCH next cycle; irwrite=1, pcwrite=1, memwrite=0, regwrite=0.
- op=0000011 from reset. Required:
  - states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH
  - regwrite only in cycle 5 with resultsrc 01
  - immsrc 000
- op=0100011. Required: memwrite=1 only in cycle 4 with adrsrc 1; immsrc 001; 4 cycles.
- op=0110011, funct3 000, funct7b5 1. Required: alucontrol 001 in EXECUTER; regwrite in ALUWB.
- op=1100011, zero=1. Required: pcwrite=1 in BEQ. With zero=0: pcwrite=0 in BEQ. Both cases: immsrc 010, back to FETCH after 3 cycles.
- op=1111111. Required: TRAP after DECODE; illegal=1 and all enables 0 for 20 cycles; reset returns to FETCH.
